// File: rtl/param_load_counter.sv
// Parametrised load counter: programmable modulus, up/down, wrap or saturate,
// registered terminal-count pulse and sticky overflow flag.
module param_load_counter #(
    parameter int unsigned WIDTH   = 8,
    parameter int unsigned MOD_MAX = (2 ** WIDTH) - 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             up_dn,
    input  logic             sat_mode,
    input  logic             clr_ovf,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             ovf,
    output logic             at_zero,
    output logic             at_max
);

    localparam logic [WIDTH-1:0] MAX_V  = WIDTH'(MOD_MAX);
    localparam logic [WIDTH-1:0] ZERO_V = '0;
    localparam logic [WIDTH-1:0] ONE_V  = WIDTH'(1);

    logic [WIDTH-1:0] count_nxt;
    logic             tc_nxt;
    logic             ovf_nxt;
    logic             boundary;

    // Bound flags straight off the count register
    assign at_zero = (count == ZERO_V);
    assign at_max  = (count == MAX_V);

    // Next-state: load beats count beats hold; boundary events drive tc and ovf
    always_comb begin
        count_nxt = count;
        tc_nxt    = 1'b0;
        ovf_nxt   = ovf & ~clr_ovf;
        boundary  = up_dn ? at_max : at_zero;
        if (load) begin
            count_nxt = (load_val > MAX_V) ? MAX_V : load_val;
        end else if (en) begin
            if (boundary) begin
                tc_nxt  = 1'b1;
                ovf_nxt = 1'b1;
                if (!sat_mode) begin
                    count_nxt = up_dn ? ZERO_V : MAX_V;
                end
            end else begin
                count_nxt = up_dn ? (count + ONE_V) : (count - ONE_V);
            end
        end
    end

    // State register with asynchronous clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
            tc    <= 1'b0;
            ovf   <= 1'b0;
        end else begin
            count <= count_nxt;
            tc    <= tc_nxt;
            ovf   <= ovf_nxt;
        end
    end

endmodule

// File: tb/tb_param_load_counter.sv
module tb_param_load_counter;

    localparam int unsigned WIDTH   = 4;
    localparam int unsigned MOD_MAX = 9;

    logic             clk;
    logic             rst_n;
    logic             en;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic             up_dn;
    logic             sat_mode;
    logic             clr_ovf;
    logic [WIDTH-1:0] count;
    logic             tc;
    logic             ovf;
    logic             at_zero;
    logic             at_max;

    typedef struct packed {
        logic [WIDTH-1:0] count;
        logic             tc;
        logic             ovf;
        logic             az;
        logic             am;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks;
    int   n_fail;
    int   m_count;
    bit   m_ovf;

    param_load_counter #(.WIDTH(WIDTH), .MOD_MAX(MOD_MAX)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .load     (load),
        .load_val (load_val),
        .up_dn    (up_dn),
        .sat_mode (sat_mode),
        .clr_ovf  (clr_ovf),
        .count    (count),
        .tc       (tc),
        .ovf      (ovf),
        .at_zero  (at_zero),
        .at_max   (at_max)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    // One clock: drive inputs, predict with a modular-arithmetic model, compare after the edge
    task automatic step(input bit e, input bit l, input int lv, input bit ud,
                        input bit sm, input bit co, input string tag);
        int   n;
        bit   bnd;
        bit   t;
        exp_t x;
        en       = e;
        load     = l;
        load_val = WIDTH'(lv);
        up_dn    = ud;
        sat_mode = sm;
        clr_ovf  = co;
        bnd = 1'b0;
        if (l) begin
            m_count = (lv > int'(MOD_MAX)) ? int'(MOD_MAX) : lv;
        end else if (e) begin
            n = m_count + (ud ? 1 : -1);
            if (n < 0 || n > int'(MOD_MAX)) begin
                bnd = 1'b1;
                if (!sm) m_count = (n + int'(MOD_MAX) + 1) % (int'(MOD_MAX) + 1);
            end else begin
                m_count = n;
            end
        end
        t     = bnd;
        m_ovf = bnd | (m_ovf & ~co);
        x.count = WIDTH'(m_count);
        x.tc    = t;
        x.ovf   = m_ovf;
        x.az    = (m_count == 0);
        x.am    = (m_count == int'(MOD_MAX));
        exp_q.push_back(x);
        @(posedge clk);
        #1;
        x = exp_q.pop_front();
        check_eq({tag, ".count"}, int'(count), int'(x.count));
        check_eq({tag, ".tc"}, int'(tc), int'(x.tc));
        check_eq({tag, ".ovf"}, int'(ovf), int'(x.ovf));
        check_eq({tag, ".at_zero"}, int'(at_zero), int'(x.az));
        check_eq({tag, ".at_max"}, int'(at_max), int'(x.am));
    endtask

    // Reset mid-cycle and confirm outputs clear before any clock edge
    task automatic async_reset(input string tag);
        #3;
        rst_n = 1'b0;
        #1;
        check_eq({tag, ".count"}, int'(count), 0);
        check_eq({tag, ".tc"}, int'(tc), 0);
        check_eq({tag, ".ovf"}, int'(ovf), 0);
        m_count = 0;
        m_ovf   = 1'b0;
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        m_count  = 0;
        m_ovf    = 1'b0;
        rst_n    = 1'b0;
        en       = 1'b0;
        load     = 1'b0;
        load_val = '0;
        up_dn    = 1'b1;
        sat_mode = 1'b0;
        clr_ovf  = 1'b0;
        #12;
        check_eq("rst.count", int'(count), 0);
        check_eq("rst.tc", int'(tc), 0);
        check_eq("rst.ovf", int'(ovf), 0);
        check_eq("rst.at_zero", int'(at_zero), 1);
        rst_n = 1'b1;

        // Reset from count=5 with ovf set
        step(0, 1, 9, 1, 0, 0, "pre_ld9");
        step(1, 0, 0, 1, 0, 0, "pre_wrap");
        step(0, 1, 5, 1, 0, 0, "pre_ld5");
        async_reset("rst_mid5");

        // Decade wrap from 0
        for (int i = 0; i < 12; i++) step(1, 0, 0, 1, 0, 0, "decade");

        // Reset during a tc pulse
        step(0, 1, 9, 1, 0, 0, "ld9b");
        step(1, 0, 0, 1, 0, 0, "wrap_b");
        check_eq("pulse.tc_before_rst", int'(tc), 1);
        async_reset("rst_pulse");

        // Down saturate from 2
        step(0, 1, 2, 0, 1, 0, "ld2");
        for (int i = 0; i < 5; i++) step(1, 0, 0, 0, 1, 0, "dn_sat");

        // Load priority over en, and clamp
        step(1, 1, 14, 1, 0, 0, "ld_clamp");
        step(1, 0, 0, 1, 0, 0, "clamp_wrap");

        // Overflow clear, then clear racing a wrap
        step(0, 0, 0, 1, 0, 1, "clr_ovf");
        step(0, 1, 9, 1, 0, 0, "ld9c");
        step(1, 0, 0, 1, 0, 1, "clr_race");

        // Hold at max and at zero
        step(0, 1, 9, 1, 0, 0, "ld9d");
        for (int i = 0; i < 3; i++) step(0, 0, 0, 1, 0, 0, "hold_max");
        step(0, 1, 0, 1, 0, 0, "ld0");
        step(0, 0, 0, 1, 0, 0, "hold_zero");

        // Up saturate at max
        step(0, 1, 8, 1, 1, 0, "ld8");
        for (int i = 0; i < 3; i++) step(1, 0, 0, 1, 1, 0, "up_sat");

        // Random mix of controls
        for (int i = 0; i < 60; i++) begin
            step(bit'($urandom_range(0, 3) != 0), bit'($urandom_range(0, 7) == 0),
                 int'($urandom_range(0, 15)), bit'($urandom_range(0, 1)),
                 bit'($urandom_range(0, 1)), bit'($urandom_range(0, 5) == 0), "rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
